// File: rtl/riscv_code_ahb_resp.sv
// riscv_code_ahb_resp
//   AHB-Lite responder for the instruction-fetch code port. Serves 32-bit
//   reads from a word-organised code memory with WAIT_STATES wait cycles per
//   data phase. It answers illegal transfers with a two-cycle ERROR response.
//   A loader port preloads the memory directly, bypassing the bus.
//   Optional feature macro: RISCV_CODE_RESP_WRERR_EN (writes become ERROR).
module riscv_code_ahb_resp #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           HSEL,
    input  logic [31:0]                    HADDR,
    input  logic [1:0]                     HTRANS,
    input  logic                           HWRITE,
    input  logic [2:0]                     HSIZE,
    input  logic [2:0]                     HBURST,
    input  logic [3:0]                     HPROT,
    input  logic                           HMASTLOCK,
    input  logic                           HREADY,
    output logic [31:0]                    HRDATA,
    output logic                           HREADYOUT,
    output logic                           HRESP,
    input  logic                           ld_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [31:0]                    ld_wdata
);

    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN_BYTES  = 33'(DEPTH_WORDS) << 2;
    // The counter holds the wait cycles still to go after the current one.
    localparam logic [3:0]  WAIT_RELOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        mem [DEPTH_WORDS];
    logic [31:0]        rd_buf;
    logic [31:0]        hrdata_q;

    logic               open_phase;
    logic               accept;
    logic [31:0]        offset;
    logic               in_range;
    logic               write_ok;
    logic               legal;
    logic               capture;
    logic [IDX_W-1:0]   idx;
    logic               unused_ok;

    // An address phase can only be taken while the current data phase completes.
    assign open_phase = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    assign accept     = open_phase && HSEL && HTRANS[1] && HREADY;

    // Unsigned distance from BASE_ADDR. Addresses below the base are rejected
    // explicitly, so a wrapped difference can never look legal.
    assign offset   = HADDR - BASE_ADDR;
    assign in_range = (HADDR >= BASE_ADDR) && ({1'b0, offset} < SPAN_BYTES);
    assign idx      = offset[IDX_W+1:2];

`ifdef RISCV_CODE_RESP_WRERR_EN
    assign write_ok = !HWRITE;
`else
    assign write_ok = 1'b1;
`endif

    assign legal   = (HSIZE == 3'h2) && (HADDR[1:0] == 2'b00) && in_range && write_ok;
    assign capture = accept && legal && !HWRITE;

    // Burst type, protection and lock are accepted but carry no meaning here.
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], offset[31:IDX_W+2], offset[1:0]};

    // State and wait-counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: wait countdown, two-cycle error, new transfer decode.
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal
        // unassigned and a latch cannot be inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (!legal) begin
                        state_d = ST_ERR1;
                    end else if (HWRITE) begin
                        // Write to code space without error checking: OKAY, no effect.
                        state_d = ST_IDLE;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_RELOAD;
                    end
                end
            end
        endcase
    end

    // Loader write port into the code memory.
    always_ff @(posedge CLK) begin
        // NOTE: the memory array has no reset; its contents must survive a bus
        // reset, and resetting a RAM would stop it mapping onto a macro.
        if (ld_we) begin
            mem[ld_addr] <= ld_wdata;
        end
    end

    // Read data: captured at address phase and presented on entry to DATA.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_buf   <= 32'd0;
            hrdata_q <= 32'd0;
        end else begin
            if (capture) begin
                rd_buf <= mem[idx];
            end
            case (state_d)
                ST_DATA:          hrdata_q <= capture ? mem[idx] : rd_buf;
                ST_ERR1, ST_ERR2: hrdata_q <= 32'd0;
                default:          hrdata_q <= hrdata_q;
            endcase
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);

endmodule

// File: tb/tb_riscv_code_ahb_resp.sv
// tb_riscv_code_ahb_resp
//   Three responder instances (0, 2 and 3 wait states) on a shared bus. Only
//   the instance under test is selected. Each instance's HREADY input is tied
//   to its own HREADYOUT, as on a single-responder bus. Each cycle pushes the
//   expected response to a scoreboard queue; it is popped and compared after
//   the edge.
module tb_riscv_code_ahb_resp;

    localparam int          DEPTH = 16;
    localparam logic [1:0]  T_IDLE = 2'b00;
    localparam logic [1:0]  T_BUSY = 2'b01;
    localparam logic [1:0]  T_NSEQ = 2'b10;
    localparam logic [1:0]  T_SEQ  = 2'b11;
    localparam logic [2:0]  SZ_W   = 3'h2;

    localparam logic [31:0] A0 = 32'hA0A0_0000;
    localparam logic [31:0] A1 = 32'hA1A1_0001;
    localparam logic [31:0] A2 = 32'hA2A2_0002;
    localparam logic [31:0] A3 = 32'hA3A3_0003;
    localparam logic [31:0] M4 = 32'hDEAD_BEEF;
    localparam logic [31:0] M5 = 32'h5555_0005;
    localparam logic [31:0] M5N = 32'h5555_AAAA;
    localparam logic [31:0] M6 = 32'h600D_CAFE;
    localparam logic [31:0] M15 = 32'hF00D_000F;

    logic        CLK = 1'b0;
    logic        RST;
    logic        hsel_v;
    int          sel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        ld_we;
    logic [3:0]  ld_addr;
    logic [31:0] ld_wdata;

    logic        ready_w [3];
    logic        resp_w  [3];
    logic [31:0] data_w  [3];

    typedef struct {
        int          k;
        logic        rdy;
        logic        rsp;
        logic [31:0] data;
        string       name;
    } exp_t;

    typedef struct {
        logic        hsel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic        rdy;
        logic        rsp;
        logic [31:0] data;
        string       name;
    } vec_t;

    exp_t sb [$];
    vec_t vecs [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    riscv_code_ahb_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
        .CLK(CLK), .RST(RST), .HSEL(hsel_v && (sel == 0)), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
        .HREADY(ready_w[0]), .HRDATA(data_w[0]), .HREADYOUT(ready_w[0]), .HRESP(resp_w[0]),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata)
    );

    riscv_code_ahb_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_ws2 (
        .CLK(CLK), .RST(RST), .HSEL(hsel_v && (sel == 1)), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
        .HREADY(ready_w[1]), .HRDATA(data_w[1]), .HREADYOUT(ready_w[1]), .HRESP(resp_w[1]),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata)
    );

    riscv_code_ahb_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
        .CLK(CLK), .RST(RST), .HSEL(hsel_v && (sel == 2)), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
        .HREADY(ready_w[2]), .HRDATA(data_w[2]), .HREADYOUT(ready_w[2]), .HRESP(resp_w[2]),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
        end
    endtask

    // Drive one address phase, then compare the response seen after the edge.
    task automatic step(input int k, input logic rst, input logic s, input logic [31:0] a,
                        input logic [1:0] t, input logic w, input logic [2:0] z,
                        input logic e_rdy, input logic e_rsp, input logic [31:0] e_data,
                        input string name);
        exp_t e;
        RST    = rst;
        sel    = k;
        hsel_v = s;
        haddr  = a;
        htrans = t;
        hwrite = w;
        hsize  = z;
        sb.push_back('{k, e_rdy, e_rsp, e_data, name});
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        check({e.name, ".hreadyout"}, 32'(ready_w[e.k]), 32'(e.rdy));
        check({e.name, ".hresp"},     32'(resp_w[e.k]),  32'(e.rsp));
        check({e.name, ".hrdata"},    data_w[e.k],       e.data);
    endtask

    task automatic idle(input int k, input logic e_rdy, input logic e_rsp,
                        input logic [31:0] e_data, input string name);
        step(k, 1'b0, 1'b0, 32'h0, T_IDLE, 1'b0, SZ_W, e_rdy, e_rsp, e_data, name);
    endtask

    task automatic rd(input int k, input logic [31:0] a, input logic e_rdy, input logic e_rsp,
                      input logic [31:0] e_data, input string name);
        step(k, 1'b0, 1'b1, a, T_NSEQ, 1'b0, SZ_W, e_rdy, e_rsp, e_data, name);
    endtask

    initial begin
        logic [31:0] img [DEPTH];

        RST = 1'b1; sel = 0; hsel_v = 1'b0; haddr = 32'h0; htrans = T_IDLE;
        hwrite = 1'b0; hsize = SZ_W; ld_we = 1'b0; ld_addr = 4'd0; ld_wdata = 32'h0;

        // Reset state.
        step(0, 1'b1, 1'b0, 32'h0, T_IDLE, 1'b0, SZ_W, 1'b1, 1'b0, 32'h0, "rst0");
        step(0, 1'b1, 1'b0, 32'h0, T_IDLE, 1'b0, SZ_W, 1'b1, 1'b0, 32'h0, "rst1");
        RST = 1'b0;

        // Image preload through the loader port (all instances).
        for (int i = 0; i < DEPTH; i++) img[i] = 32'hC0DE_0000 + 32'(i);
        img[0] = A0; img[1] = A1; img[2] = A2; img[3] = A3;
        img[4] = M4; img[5] = M5; img[6] = M6; img[15] = M15;
        for (int i = 0; i < DEPTH; i++) begin
            ld_we = 1'b1; ld_addr = 4'(i); ld_wdata = img[i];
            @(posedge CLK);
            #1;
        end
        ld_we = 1'b0;

        // Zero-wait vectors on instance 0: inputs of one address phase and the
        // response expected in the following cycle.
        vecs.push_back('{1'b1, 32'h00, T_NSEQ, 1'b0, SZ_W,   1'b1, 1'b0, A0,    "t1_rd0"});
        vecs.push_back('{1'b1, 32'h04, T_SEQ,  1'b0, SZ_W,   1'b1, 1'b0, A1,    "t1_rd4"});
        vecs.push_back('{1'b1, 32'h08, T_SEQ,  1'b0, SZ_W,   1'b1, 1'b0, A2,    "t1_rd8"});
        vecs.push_back('{1'b1, 32'h0C, T_SEQ,  1'b0, SZ_W,   1'b1, 1'b0, A3,    "t1_rdc"});
        vecs.push_back('{1'b0, 32'h00, T_IDLE, 1'b0, SZ_W,   1'b1, 1'b0, A3,    "t1_hold"});
        vecs.push_back('{1'b1, 32'h3C, T_NSEQ, 1'b0, SZ_W,   1'b1, 1'b0, M15,   "last_word"});
        vecs.push_back('{1'b1, 32'h02, T_NSEQ, 1'b0, SZ_W,   1'b0, 1'b1, 32'h0, "t3_mis_err1"});
        vecs.push_back('{1'b0, 32'h00, T_IDLE, 1'b0, SZ_W,   1'b1, 1'b1, 32'h0, "t3_mis_err2"});
        vecs.push_back('{1'b0, 32'h00, T_IDLE, 1'b0, SZ_W,   1'b1, 1'b0, 32'h0, "t3_mis_idle"});
        vecs.push_back('{1'b1, 32'h04, T_NSEQ, 1'b0, 3'h1,   1'b0, 1'b1, 32'h0, "t3_sz_err1"});
        vecs.push_back('{1'b0, 32'h00, T_IDLE, 1'b0, SZ_W,   1'b1, 1'b1, 32'h0, "t3_sz_err2"});
        vecs.push_back('{1'b1, 32'h00, T_NSEQ, 1'b0, SZ_W,   1'b1, 1'b0, A0,    "err2_accept"});
        vecs.push_back('{1'b1, 32'h40, T_NSEQ, 1'b0, SZ_W,   1'b0, 1'b1, 32'h0, "t4_oor_err1"});
        vecs.push_back('{1'b0, 32'h00, T_IDLE, 1'b0, SZ_W,   1'b1, 1'b1, 32'h0, "t4_oor_err2"});
        vecs.push_back('{1'b1, 32'h00, T_NSEQ, 1'b0, SZ_W,   1'b1, 1'b0, A0,    "t4_rd0"});
        vecs.push_back('{1'b1, 32'h04, T_NSEQ, 1'b0, SZ_W,   1'b1, 1'b0, A1,    "pre_wr_rd4"});
`ifdef RISCV_CODE_RESP_WRERR_EN
        vecs.push_back('{1'b1, 32'h08, T_NSEQ, 1'b1, SZ_W,   1'b0, 1'b1, 32'h0, "t5_wr_err1"});
        vecs.push_back('{1'b0, 32'h00, T_IDLE, 1'b0, SZ_W,   1'b1, 1'b1, 32'h0, "t5_wr_err2"});
`else
        vecs.push_back('{1'b1, 32'h08, T_NSEQ, 1'b1, SZ_W,   1'b1, 1'b0, A1,    "t5_wr_okay"});
        vecs.push_back('{1'b0, 32'h00, T_IDLE, 1'b0, SZ_W,   1'b1, 1'b0, A1,    "t5_wr_idle"});
`endif
        vecs.push_back('{1'b1, 32'h08, T_NSEQ, 1'b0, SZ_W,   1'b1, 1'b0, A2,    "t5_readback"});
        vecs.push_back('{1'b0, 32'h00, T_NSEQ, 1'b0, SZ_W,   1'b1, 1'b0, A2,    "unselected"});
        vecs.push_back('{1'b1, 32'h00, T_BUSY, 1'b0, SZ_W,   1'b1, 1'b0, A2,    "busy"});
        vecs.push_back('{1'b1, 32'hFFFF_FFFC, T_NSEQ, 1'b0, SZ_W, 1'b0, 1'b1, 32'h0, "high_err1"});
        vecs.push_back('{1'b0, 32'h00, T_IDLE, 1'b0, SZ_W,   1'b1, 1'b1, 32'h0, "high_err2"});
        vecs.push_back('{1'b0, 32'h00, T_IDLE, 1'b0, SZ_W,   1'b1, 1'b0, 32'h0, "high_idle"});

        foreach (vecs[i]) begin
            step(0, 1'b0, vecs[i].hsel, vecs[i].addr, vecs[i].trans, vecs[i].wr, vecs[i].size,
                 vecs[i].rdy, vecs[i].rsp, vecs[i].data, vecs[i].name);
        end

        // Loader write and bus read of the same word in one cycle: old data.
        ld_we = 1'b1; ld_addr = 4'd5; ld_wdata = M5N;
        rd(0, 32'h14, 1'b1, 1'b0, M5, "ld_collide_old");
        ld_we = 1'b0;
        rd(0, 32'h14, 1'b1, 1'b0, M5N, "ld_collide_new");

        // Two wait states, then a back-to-back read issued in the DATA cycle.
        rd  (1, 32'h10, 1'b0, 1'b0, 32'h0, "t2_w1");
        idle(1,         1'b0, 1'b0, 32'h0, "t2_w2");
        idle(1,         1'b1, 1'b0, M4,    "t2_data");
        rd  (1, 32'h00, 1'b0, 1'b0, M4,    "t2b_w1");
        idle(1,         1'b0, 1'b0, M4,    "t2b_w2");
        idle(1,         1'b1, 1'b0, A0,    "t2b_data");
        rd  (1, 32'h02, 1'b0, 1'b1, 32'h0, "t2_err1");
        idle(1,         1'b1, 1'b1, 32'h0, "t2_err2");
        idle(1,         1'b1, 1'b0, 32'h0, "t2_idle");

        // Three wait states; reset lands in the middle of a wait.
        rd  (2, 32'h18, 1'b0, 1'b0, 32'h0, "t6_w1");
        idle(2,         1'b0, 1'b0, 32'h0, "t6_w2");
        idle(2,         1'b0, 1'b0, 32'h0, "t6_w3");
        idle(2,         1'b1, 1'b0, M6,    "t6_data");
        rd  (2, 32'h00, 1'b0, 1'b0, M6,    "t6_pre_rst_w");
        step(2, 1'b1, 1'b0, 32'h0, T_IDLE, 1'b0, SZ_W, 1'b1, 1'b0, 32'h0, "t6_rst");
        rd  (2, 32'h18, 1'b0, 1'b0, 32'h0, "t6_re_w1");
        idle(2,         1'b0, 1'b0, 32'h0, "t6_re_w2");
        idle(2,         1'b0, 1'b0, 32'h0, "t6_re_w3");
        idle(2,         1'b1, 1'b0, M6,    "t6_re_data");
        rd  (0, 32'h14, 1'b1, 1'b0, M5N,   "t6_ld_kept");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
